// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath blocks.
//   state_t        : sequencer FSM encoding (idle / weight load / inference run)
//   CFG_ID_W       : width of the layer and neuron ID fields on the config bus
//   DEF_DATA_WIDTH : default weight and input-sample width
//   DEF_ADDR_WIDTH : default weight RAM address width
package nn_pkg;

  localparam int unsigned CFG_ID_W       = 8;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/neuron_weight_sequencer_wrap_counter.sv
// Modulo-MODULUS up-counter. It advances on i_en and wraps to zero after
// MODULUS-1.
//   clk, rst_n : clock and asynchronous active-low reset (count clears to 0)
//   i_en       : advance the count by one this cycle
//   o_cnt      : current count
//   o_tc       : terminal count, high while o_cnt == MODULUS-1
module wrap_counter #(
  parameter int unsigned MODULUS = 4,
  parameter int unsigned WIDTH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

endmodule

// File: rtl/neuron_weight_sequencer.sv
// Per-neuron weight sequencer. It loads the neuron's weight RAM from the
// broadcast config bus. During inference it pairs each accepted input sample
// with its stored weight and presents the pair to the MAC.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cfg_valid/_layer/_neuron/_data, cfg_ready : config bus (ID-filtered)
//   x_valid, x_in, x_ready                    : input sample stream
//   mem_wen/_wadd/_win                        : RAM write port (zero latency)
//   mem_ren/_radd, mem_rdata                  : RAM read port (1-cycle read)
//   op_valid/_x/_w/_last                      : aligned operand pair to the MAC
//   loaded                                    : a complete weight set is stored
//   busy                                      : FSM not idle
module neuron_weight_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned NUM_WEIGHT = 784,
  parameter int unsigned LAYER_NO   = 1,
  parameter int unsigned NEURON_NO  = 0,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  input  logic [CFG_ID_W-1:0]   cfg_layer,
  input  logic [CFG_ID_W-1:0]   cfg_neuron,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  cfg_ready,
  input  logic                  x_valid,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic                  x_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_wadd,
  output logic [DATA_WIDTH-1:0] mem_win,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  op_valid,
  output logic [DATA_WIDTH-1:0] op_x,
  output logic [DATA_WIDTH-1:0] op_w,
  output logic                  op_last,
  output logic                  loaded,
  output logic                  busy
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_loaded;
  logic                  r_op_valid;
  logic [DATA_WIDTH-1:0] r_op_x;
  logic                  r_op_last;

  logic                  w_cfg_match;
  logic                  w_cfg_ready;
  logic                  w_cfg_hit;
  logic                  w_x_ready;
  logic                  w_x_acc;
  logic                  w_set_loaded;
  logic                  w_clr_loaded;
  logic [ADDR_WIDTH-1:0] w_wr_cnt;
  logic [ADDR_WIDTH-1:0] w_rd_cnt;
  logic                  w_wr_tc;
  logic                  w_rd_tc;

  assign w_cfg_match = (cfg_layer == CFG_ID_W'(LAYER_NO)) &&
                       (cfg_neuron == CFG_ID_W'(NEURON_NO));

  wrap_counter #(
    .MODULUS (NUM_WEIGHT),
    .WIDTH   (ADDR_WIDTH)
  ) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_cfg_hit),
    .o_cnt (w_wr_cnt),
    .o_tc  (w_wr_tc)
  );

  wrap_counter #(
    .MODULUS (NUM_WEIGHT),
    .WIDTH   (ADDR_WIDTH)
  ) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_x_acc),
    .o_cnt (w_rd_cnt),
    .o_tc  (w_rd_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_set_loaded = 1'b0;
    w_clr_loaded = 1'b0;
    w_cfg_ready  = (r_state != ST_RUN);
    w_cfg_hit    = cfg_valid & w_cfg_ready & w_cfg_match;
    // Config takes priority over a sample arriving in the same IDLE cycle.
    w_x_ready    = r_loaded & (((r_state == ST_IDLE) & ~w_cfg_hit) |
                               (r_state == ST_RUN));
    w_x_acc      = x_valid & w_x_ready;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cfg_hit) begin
          if (w_wr_cnt == '0) begin
            w_state_nxt  = ST_LOAD;
            w_clr_loaded = 1'b1;
          end
        end else if (w_x_acc) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (w_cfg_hit && w_wr_tc) begin
          w_state_nxt  = ST_IDLE;
          w_set_loaded = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_x_acc && w_rd_tc) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loaded <= 1'b0;
    end else if (w_set_loaded) begin
      r_loaded <= 1'b1;
    end else if (w_clr_loaded) begin
      r_loaded <= 1'b0;
    end
  end

  // The sample is delayed one cycle so that it lines up with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_valid <= 1'b0;
      r_op_x     <= '0;
      r_op_last  <= 1'b0;
    end else begin
      r_op_valid <= w_x_acc;
      r_op_last  <= w_x_acc & w_rd_tc;
      if (w_x_acc) begin
        r_op_x <= x_in;
      end
    end
  end

  assign cfg_ready = w_cfg_ready;
  assign x_ready   = w_x_ready;
  assign mem_wen   = w_cfg_hit;
  assign mem_wadd  = w_wr_cnt;
  assign mem_win   = cfg_data;
  assign mem_ren   = w_x_acc;
  assign mem_radd  = w_rd_cnt;
  assign op_valid  = r_op_valid;
  assign op_x      = r_op_x;
  assign op_w      = mem_rdata;
  assign op_last   = r_op_last;
  assign loaded    = r_loaded;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/neuron_weight_sequencer.md
Name: neuron_weight_sequencer

Overview:
- Per-neuron controller that owns one neuron's weight RAM port pair (1-cycle registered-read RAM, separate write and read ports, 10-bit addresses, 16-bit data).
- Load path: writes weights from a broadcast config bus filtered by layer/neuron ID.
- Inference path: pairs each accepted input sample with its weight and emits aligned operands to the neuron MAC.
- Sits between the layer-level config/input fabric and the neuron's weight RAM plus MAC.

Parameters:
- NUM_WEIGHT, 784: weights per neuron; valid range 2..1024.
- LAYER_NO, 1: layer ID this instance answers to on the config bus.
- NEURON_NO, 0: neuron ID this instance answers to.
- DATA_WIDTH, 16: weight and input sample width.
- ADDR_WIDTH, 10: RAM address width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config beat valid.
- cfg_layer  in  8  target layer ID.
- cfg_neuron  in  8  target neuron ID.
- cfg_data  in  DATA_WIDTH  weight value.
- cfg_ready  out  1  config beat may be taken.
- x_valid  in  1  input sample valid.
- x_in  in  DATA_WIDTH  input sample.
- x_ready  out  1  sample may be taken.
- mem_wen  out  1  RAM write enable.
- mem_wadd  out  ADDR_WIDTH  RAM write address.
- mem_win  out  DATA_WIDTH  RAM write data.
- mem_ren  out  1  RAM read enable.
- mem_radd  out  ADDR_WIDTH  RAM read address.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_ren.
- op_valid  out  1  operand pair valid.
- op_x  out  DATA_WIDTH  delayed input sample.
- op_w  out  DATA_WIDTH  matching weight; equals mem_rdata.
- op_last  out  1  marks the pair for weight index NUM_WEIGHT-1.
- loaded  out  1  full weight set present.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, LOAD, RUN. Counters wr_cnt and rd_cnt are ADDR_WIDTH wide.
- Reset (async assert, sync deassert):
  - state=IDLE; wr_cnt=rd_cnt=0.
  - loaded=0, op_valid=0, op_x=0, op_last=0, mem_wen=0, mem_ren=0.
  - RAM contents are untouched.
- cfg_hit = cfg_valid & cfg_ready & (cfg_layer==LAYER_NO) & (cfg_neuron==NEURON_NO).
- Non-matching beats:
  - Accepted with cfg_ready=1 in IDLE and LOAD.
  - No write and no state change.
- Ready generation (combinational):
  - cfg_ready = (state != RUN).
  - x_ready = loaded & ((state==IDLE & ~cfg_hit) | state==RUN).
  - Config wins a simultaneous IDLE collision.
- Write path:
  - mem_wen = cfg_hit; mem_wadd = wr_cnt; mem_win = cfg_data. All combinational, zero latency.
  - Each hit increments wr_cnt.
  - A hit at wr_cnt==NUM_WEIGHT-1 wraps wr_cnt to 0.
- Read path:
  - Sample accepted (x_valid & x_ready) at cycle N: mem_ren=1, mem_radd=rd_cnt, x_in registered.
  - Cycle N+1: op_valid=1, op_x=registered sample, op_w=mem_rdata.
  - op_last=1 iff the registered rd_cnt was NUM_WEIGHT-1.
  - rd_cnt increments and wraps to 0 after NUM_WEIGHT-1.
  - Throughput: one pair per cycle. No backpressure on op_*.
- State transitions:
  - IDLE→LOAD on cfg_hit with wr_cnt==0. loaded is cleared on that same edge.
  - LOAD→IDLE on the hit at wr_cnt==NUM_WEIGHT-1. loaded is set on that edge.
  - IDLE→RUN on the first accepted sample.
  - RUN→IDLE on acceptance at rd_cnt==NUM_WEIGHT-1. The final op_valid still issues on the next cycle.
- Gaps:
  - x_valid low during RUN: rd_cnt holds, op_valid=0 the next cycle.
  - cfg gaps during LOAD: wr_cnt holds.
- Reset mid-LOAD: loaded stays 0; the next load restarts at address 0.
- Reset mid-RUN: the partial pass is discarded; rd_cnt=0, and any in-flight op_valid is suppressed.
- Since loaded is reset to 0, weights preloaded by RAM init are unusable until a full reload. This is required.

Decomposition:
- Shared package nn_pkg:
  - State encoding (ST_IDLE/ST_LOAD/ST_RUN, 2 bits).
  - Config ID width (8).
  - Default DATA_WIDTH/ADDR_WIDTH.
- One natural sub-module: wrap_counter (parameterised modulus, enable, async active-low reset, terminal-count flag), instantiated twice for wr_cnt and rd_cnt.

Test Plan (NUM_WEIGHT=4, LAYER_NO=1, NEURON_NO=2):
- Load: 4 matching beats 0x0011..0x0044, back-to-back.
  - mem_wadd 0,1,2,3 with mem_wen=1.
  - loaded=1 the cycle after the 4th beat; state back to IDLE.
- Filtering: beats with neuron=3 or layer=0 interleaved.
  - cfg_ready=1, mem_wen=0 on those beats, wr_cnt unchanged.
- Inference: x 1,2,3,4 back-to-back after load.
  - mem_radd 0..3.
  - op_valid on cycles N+1..N+4 with pairs (1,0x11)..(4,0x44).
  - op_last only on the 4th pair.
- Stall and collision:
  - x_valid dropped for 2 cycles mid-RUN: no op_valid, rd_cnt holds, resumes at the correct index.
  - Matching cfg and x in IDLE in the same cycle: write occurs, x_ready=0.
- Reset mid-RUN after 2 samples:
  - All outputs return to reset values and loaded=0.
  - x_ready stays 0 until a full reload.
  - After reload, the pass starts at radd 0.
